// File: rtl/bp_me_mem_cmd_arbiter.sv
// Memory command arbiter: round-robin shares one bp_mem port among several
// cache engines. An in-order FIFO of requester IDs steers each memory
// response back to the requester that issued the matching command.
// There are no registers on the command or response data paths.
module bp_me_mem_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,

    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_ready_o,
    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_yumi_i,

    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,

    output logic                             idle_o,
    output logic                             err_o
);

    localparam int id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int lg_lp   = $clog2(max_outstanding_p);

    logic [id_w_lp-1:0] ptr_r;
    logic [id_w_lp-1:0] grant;
    logic [id_w_lp-1:0] grant_nxt;
    logic               any_v;
    logic               fire;

    logic [id_w_lp-1:0] id_mem_r [max_outstanding_p];
    logic [lg_lp-1:0]   wr_ptr_r;
    logic [lg_lp-1:0]   rd_ptr_r;
    logic [lg_lp:0]     count_r;
    logic               full;
    logic               empty;
    logic [id_w_lp-1:0] head;
    logic               resp_ok;
    logic               pop;
    logic               err_r;

    assign full  = (count_r == (lg_lp+1)'(max_outstanding_p));
    assign empty = (count_r == '0);
    assign any_v = |req_cmd_v_i;
    assign head  = id_mem_r[rd_ptr_r];

    // Cyclic priority search: first valid requester at index >= ptr.
    always_comb begin : grant_search
        logic [id_w_lp:0] idx;
        logic             found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = {1'b0, ptr_r} + (id_w_lp+1)'(k);
            if (idx >= (id_w_lp+1)'(num_req_p))
                idx = idx - (id_w_lp+1)'(num_req_p);
            if (!found && req_cmd_v_i[idx[id_w_lp-1:0]]) begin
                grant = idx[id_w_lp-1:0];
                found = 1'b1;
            end
        end
    end

    // Full blocks issue even if a pop lands this cycle; keeps ready off the
    // response-yumi path.
    assign mem_cmd_v_o = reset_n_i & any_v & ~full;
    assign mem_cmd_o   = req_cmd_i[grant*msg_width_p +: msg_width_p];
    assign fire        = mem_cmd_v_o & mem_cmd_ready_i;
    assign grant_nxt   = (grant == id_w_lp'(num_req_p-1)) ? '0 : grant + 1'b1;

    // Acceptance handshake back to the granted requester only.
    always_comb begin
        req_cmd_ready_o = '0;
        if (fire)
            req_cmd_ready_o[grant] = 1'b1;
    end

    // Response steering: one-hot valid to the requester at the FIFO head.
    assign resp_ok    = reset_n_i & mem_resp_v_i & ~empty;
    assign req_resp_o = mem_resp_i;

    always_comb begin
        req_resp_v_o = '0;
        if (resp_ok)
            req_resp_v_o[head] = 1'b1;
    end

    assign mem_resp_yumi_o = resp_ok & req_resp_yumi_i[head];
    assign pop             = mem_resp_yumi_o;
    assign idle_o          = empty;
    assign err_o           = err_r;

    // Round-robin pointer advances past the winner on each issued command.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            ptr_r <= '0;
        else if (fire)
            ptr_r <= grant_nxt;
    end

    // ID storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk_i) begin
        if (fire)
            id_mem_r[wr_ptr_r] <= grant;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at log2 depth.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (fire)
                wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop)
                rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({fire, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error: memory presented a response with nothing outstanding.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            err_r <= 1'b0;
        else if (mem_resp_v_i && empty)
            err_r <= 1'b1;
    end

endmodule
